// File: rtl/core_c1_sb_pkg.sv
// Shared constants for the two-master system-bus arbiter slice.
package core_c1_sb_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;
  localparam int SB_SW = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WADDR = 3'd3;
  localparam logic [2:0] ST_BRESP = 3'd4;

endpackage

// File: rtl/core_c1_sb_rr2.sv
// Two-requester selector: round-robin on contention, or fixed priority to
// requester 1. gnt_o is the index of the selected requester.
module core_c1_sb_rr2 #(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = (RR_EN != 0) ? ~last_i : 1'b1;
    end else begin
      gnt_o = req_i[1];
    end
  end

endmodule

// File: rtl/core_c1_sb_arb.sv
// Two-master to one-slave system-bus arbiter with a single outstanding
// transaction; slave and master outputs are pure muxes of registered state.
module core_c1_sb_arb
  import core_c1_sb_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sb_arvalid_m0,
  output logic             sb_arready_m0,
  input  logic [SB_AW-1:0] sb_araddr_m0,
  output logic             sb_rvalid_m0,
  input  logic             sb_rready_m0,
  output logic [SB_DW-1:0] sb_rdata_m0,
  input  logic             sb_wvalid_m0,
  output logic             sb_wready_m0,
  input  logic [SB_AW-1:0] sb_waddr_m0,
  input  logic [SB_DW-1:0] sb_wdata_m0,
  input  logic [SB_SW-1:0] sb_wstrb_m0,
  output logic             sb_bvalid_m0,
  input  logic             sb_bready_m0,
  output logic             sb_bresp_m0,
  input  logic             sb_arvalid_m1,
  output logic             sb_arready_m1,
  input  logic [SB_AW-1:0] sb_araddr_m1,
  output logic             sb_rvalid_m1,
  input  logic             sb_rready_m1,
  output logic [SB_DW-1:0] sb_rdata_m1,
  input  logic             sb_wvalid_m1,
  output logic             sb_wready_m1,
  input  logic [SB_AW-1:0] sb_waddr_m1,
  input  logic [SB_DW-1:0] sb_wdata_m1,
  input  logic [SB_SW-1:0] sb_wstrb_m1,
  output logic             sb_bvalid_m1,
  input  logic             sb_bready_m1,
  output logic             sb_bresp_m1,
  output logic             sb_arvalid_s,
  input  logic             sb_arready_s,
  output logic [SB_AW-1:0] sb_araddr_s,
  input  logic             sb_rvalid_s,
  output logic             sb_rready_s,
  input  logic [SB_DW-1:0] sb_rdata_s,
  output logic             sb_wvalid_s,
  input  logic             sb_wready_s,
  output logic [SB_AW-1:0] sb_waddr_s,
  output logic [SB_DW-1:0] sb_wdata_s,
  output logic [SB_SW-1:0] sb_wstrb_s,
  input  logic             sb_bvalid_s,
  output logic             sb_bready_s,
  input  logic             sb_bresp_s,
  output logic             arb_owner,
  output logic             arb_busy
);

  logic [2:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [1:0] req;
  logic       gnt;
  logic       ownArvalid, ownRready, ownWvalid, ownBready;

  assign req = {sb_arvalid_m1 | sb_wvalid_m1, sb_arvalid_m0 | sb_wvalid_m0};

  core_c1_sb_rr2 #(.RR_EN(RR_EN)) u_rr2 (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign ownArvalid = owner_q ? sb_arvalid_m1 : sb_arvalid_m0;
  assign ownRready  = owner_q ? sb_rready_m1  : sb_rready_m0;
  assign ownWvalid  = owner_q ? sb_wvalid_m1  : sb_wvalid_m0;
  assign ownBready  = owner_q ? sb_bready_m1  : sb_bready_m0;

  // A master that withdraws its request before the address handshake simply
  // returns the bus to IDLE; last only moves on a completed response.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = gnt;
          state_d = (gnt ? sb_arvalid_m1 : sb_arvalid_m0) ? ST_RADDR : ST_WADDR;
        end
      end
      ST_RADDR: begin
        if (!ownArvalid)       state_d = ST_IDLE;
        else if (sb_arready_s) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (sb_rvalid_s && ownRready) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      ST_WADDR: begin
        if (!ownWvalid)       state_d = ST_IDLE;
        else if (sb_wready_s) state_d = ST_BRESP;
      end
      ST_BRESP: begin
        if (sb_bvalid_s && ownBready) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign sb_arvalid_s = (state_q == ST_RADDR) & ownArvalid;
  assign sb_araddr_s  = owner_q ? sb_araddr_m1 : sb_araddr_m0;
  assign sb_rready_s  = (state_q == ST_RDATA) & ownRready;
  assign sb_wvalid_s  = (state_q == ST_WADDR) & ownWvalid;
  assign sb_waddr_s   = owner_q ? sb_waddr_m1 : sb_waddr_m0;
  assign sb_wdata_s   = owner_q ? sb_wdata_m1 : sb_wdata_m0;
  assign sb_wstrb_s   = owner_q ? sb_wstrb_m1 : sb_wstrb_m0;
  assign sb_bready_s  = (state_q == ST_BRESP) & ownBready;

  assign sb_arready_m0 = (state_q == ST_RADDR) & ~owner_q & sb_arready_s;
  assign sb_arready_m1 = (state_q == ST_RADDR) &  owner_q & sb_arready_s;
  assign sb_rvalid_m0  = (state_q == ST_RDATA) & ~owner_q & sb_rvalid_s;
  assign sb_rvalid_m1  = (state_q == ST_RDATA) &  owner_q & sb_rvalid_s;
  assign sb_wready_m0  = (state_q == ST_WADDR) & ~owner_q & sb_wready_s;
  assign sb_wready_m1  = (state_q == ST_WADDR) &  owner_q & sb_wready_s;
  assign sb_bvalid_m0  = (state_q == ST_BRESP) & ~owner_q & sb_bvalid_s;
  assign sb_bvalid_m1  = (state_q == ST_BRESP) &  owner_q & sb_bvalid_s;

  assign sb_rdata_m0 = sb_rdata_s;
  assign sb_rdata_m1 = sb_rdata_s;
  assign sb_bresp_m0 = sb_bresp_s;
  assign sb_bresp_m1 = sb_bresp_s;

  assign arb_owner = owner_q;
  assign arb_busy  = (state_q != ST_IDLE);

endmodule
